regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback sources
//  (0 = pipeline writeback, 1 = mult/div completion, 2 = exception/status write).
//  Uses valid/ready handshakes, round-robin arbitration with age-based escalation,
//  and a one-cycle registered write stage.
//  Drives ctrl_writeEnable / ctrl_writeReg / data_writeReg of the regfile.
//  Exports the in-flight destination so hazard logic can see it.
// PARAMETERS
//  NUM_REQ   3   number of write requesters (2..8)
//  ADDR_W    5   register index width
//  DATA_W    32  write data width
//  MAX_WAIT  4   stalled cycles before a requester escalates above round-robin (>=1)
// PORTS
//  clock             in   1               system clock, rising edge
//  ctrl_reset_n      in   1               asynchronous, active-low reset
//  ctrl_hold         in   1               1 = grant nothing this cycle
//  req_valid         in   NUM_REQ         requester i has a write pending
//  req_reg           in   NUM_REQ*ADDR_W  dest index, slice i = [i*ADDR_W +: ADDR_W]
//  req_data          in   NUM_REQ*DATA_W  write data, slice i = [i*DATA_W +: DATA_W]
//  req_ready         out  NUM_REQ         one-hot grant (combinational)
//  ctrl_writeEnable  out  1               regfile write strobe
//  ctrl_writeReg     out  ADDR_W          regfile write index
//  data_writeReg     out  DATA_W          regfile write data
//  grant_id          out  $clog2(NUM_REQ) requester that owns the staged write
//  pending_mask      out  2**ADDR_W       one-hot of staged destination; all 0 when idle or reg 0
// BEHAVIOUR
//  - Transfer on valid[i] & ready[i]. The requester holds reg and data stable until ready.
//    Valid may drop only after a transfer.
//  - ready is at most one-hot. It is 0 for every requester when ctrl_hold=1 or no valid is asserted.
//  - Selection order:
//    - any requester with wait_cnt==MAX_WAIT wins (lowest index among those);
//    - otherwise round-robin from rr_ptr.
//  - rr_ptr resets to 0. After a grant to i, rr_ptr <= (i+1) mod NUM_REQ; unchanged if nothing is granted.
//  - wait_cnt[i]: +1 per cycle with valid & ~ready & ~hold, saturating at MAX_WAIT.
//    Cleared on grant or when valid is low. Frozen while hold=1.
//  - Write stage: the cycle after a transfer, ctrl_writeEnable=1 for exactly 1 cycle,
//    carrying that transfer's reg and data, and grant_id=i.
//    Back-to-back transfers give back-to-back writes; throughput is 1 write/cycle.
//  - Dest index 0: the transfer is accepted (ready pulses) but ctrl_writeEnable stays 0
//    and pending_mask stays 0.
//  - Two requesters may target the same register in one cycle. Only the winner proceeds;
//    the loser writes in a later cycle, so the last writer is the one granted last.
//  - Reset (async assert) sets all outputs to 0, rr_ptr=0 and all wait_cnt=0.
//    A staged write is discarded, never committed. Outputs change only on clock edges after deassert.
//  - ctrl_writeReg and data_writeReg hold their last value when ctrl_writeEnable=0.
// CONFIGURATION
//  REGFILE_ARB_FWD_EN defined: adds ports fwd_addr_a/fwd_addr_b in ADDR_W,
//    fwd_hit_a/fwd_hit_b out 1, fwd_data_a/fwd_data_b out DATA_W.
//    fwd_hit_x = ctrl_writeEnable & (fwd_addr_x == ctrl_writeReg) & (fwd_addr_x != 0).
//    fwd_data_x = data_writeReg when hit, else 0. Purely combinational.
//  REGFILE_ARB_FWD_EN undefined: these ports do not exist and there is no forwarding logic.
// STRUCTURE
//  regfile_pkg: ADDR_W, DATA_W, ZERO_REG=0, requester ids (REQ_WB=0, REQ_MD=1, REQ_EXC=2).
//  Sub-module rr_arbiter: NUM_REQ-wide combinational round-robin picker with inputs
//    (req, ptr) and one-hot output. Aging override, counters and write stage stay in the top module.
// TESTING
//  1. Reset: hold ctrl_reset_n=0 with valid=3'b111 -> ready=0, ctrl_writeEnable=0, pending_mask=0.
//  2. Single write: valid[1], reg=7, data=32'hDEADBEEF -> ready[1] in cycle 0; cycle 1 has
//     WE=1, reg=7, data=DEADBEEF, grant_id=1, pending_mask=1<<7.
//  3. Round-robin: valid=3'b111 held 6 cycles, each requester re-asserts after its grant
//     -> grant order 0,1,2,0,1,2.
//  4. Escalation: MAX_WAIT=2; req0 valid every cycle, req2 waiting. Req2 is granted no later than
//     its third valid cycle, and the bench checks wait_cnt saturates.
//  5. Reg 0 and hold: req0 reg=0 -> ready pulses, WE stays 0. Hold=1 for 3 cycles with valid
//     -> ready=0 and wait_cnt frozen; grants resume on release.
//  6. Reset mid-stream: assert reset the cycle after a transfer of reg=5 -> no write to reg 5
//     occurs and all outputs return to 0.
//     With REGFILE_ARB_FWD_EN: fwd_addr_a=5 during a staged write to 5 -> fwd_hit_a=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// the hard-wired zero register and the fixed requester ids.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 0;

  localparam int REQ_WB  = 0;
  localparam int REQ_MD  = 1;
  localparam int REQ_EXC = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr_i, wrapping around. Output is one-hot or all zero.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ sources with
// aged round-robin arbitration and a one-cycle registered write stage.
// Optional forwarding ports are enabled by defining REGFILE_ARB_FWD_EN.
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter  int NUM_REQ  = 3,
  parameter  int ADDR_W   = regfile_pkg::ADDR_W,
  parameter  int DATA_W   = regfile_pkg::DATA_W,
  parameter  int MAX_WAIT = 4,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CW       = $clog2(MAX_WAIT + 1),
  localparam int PM_W     = 2**ADDR_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset_n,
  input  logic                      ctrl_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [IDW-1:0]            grant_id,
  output logic [PM_W-1:0]           pending_mask
`ifdef REGFILE_ARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_addr_a,
  input  logic [ADDR_W-1:0]         fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b
`endif
);
  logic [NUM_REQ-1:0][CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]         esc, esc_gnt, rr_gnt, gnt;
  logic                       xfer, stage_we;
  logic [IDW-1:0]             gnt_idx;
  logic [ADDR_W-1:0]          sel_reg;
  logic [DATA_W-1:0]          sel_data;

  logic                       we_q;
  logic [ADDR_W-1:0]          reg_q;
  logic [DATA_W-1:0]          data_q;
  logic [IDW-1:0]             gid_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  // Starved requesters override round-robin; lowest index wins among them.
  always_comb begin
    esc = '0;
    for (int i = 0; i < NUM_REQ; i++)
      esc[i] = req_valid[i] && (wait_cnt_q[i] == CW'(MAX_WAIT));
  end

  assign esc_gnt   = esc & (~esc + NUM_REQ'(1));
  assign gnt       = (|esc) ? esc_gnt : rr_gnt;
  assign req_ready = (ctrl_reset_n && !ctrl_hold) ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    gnt_idx  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx  = IDW'(i);
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to the zero register are accepted but never reach the regfile.
  assign stage_we = xfer && (sel_reg != ADDR_W'(ZERO_REG));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer)
      rr_ptr_d = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    wait_cnt_d = wait_cnt_q;
    if (!ctrl_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || req_ready[i])
          wait_cnt_d[i] = '0;
        else if (wait_cnt_q[i] < CW'(MAX_WAIT))
          wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wait_cnt_q <= '0;
      rr_ptr_q   <= '0;
      we_q       <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
      gid_q      <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      we_q       <= stage_we;
      if (stage_we) begin
        reg_q  <= sel_reg;
        data_q <= sel_data;
      end
      if (xfer)
        gid_q <= gnt_idx;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = reg_q;
  assign data_writeReg    = data_q;
  assign grant_id         = gid_q;
  assign pending_mask     = we_q ? (PM_W'(1) << reg_q) : '0;

`ifdef REGFILE_ARB_FWD_EN
  assign fwd_hit_a  = we_q && (fwd_addr_a == reg_q) && (fwd_addr_a != ADDR_W'(ZERO_REG));
  assign fwd_hit_b  = we_q && (fwd_addr_b == reg_q) && (fwd_addr_b != ADDR_W'(ZERO_REG));
  assign fwd_data_a = fwd_hit_a ? data_q : '0;
  assign fwd_data_b = fwd_hit_b ? data_q : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, hand sequences for reset,
// hold and reg-0 corners, then random traffic against a behavioural model.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 2;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic              ctrl_hold;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_reg;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              ctrl_writeEnable;
  logic [AW-1:0]     ctrl_writeReg;
  logic [DW-1:0]     data_writeReg;
  logic [1:0]        grant_id;
  logic [2**AW-1:0]  pending_mask;
`ifdef REGFILE_ARB_FWD_EN
  logic [AW-1:0]     fwd_addr_a, fwd_addr_b;
  logic              fwd_hit_a, fwd_hit_b;
  logic [DW-1:0]     fwd_data_a, fwd_data_b;
`endif

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_hold        (ctrl_hold),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_id         (grant_id),
    .pending_mask     (pending_mask)
`ifdef REGFILE_ARB_FWD_EN
    ,
    .fwd_addr_a       (fwd_addr_a),
    .fwd_addr_b       (fwd_addr_b),
    .fwd_hit_a        (fwd_hit_a),
    .fwd_hit_b        (fwd_hit_b),
    .fwd_data_a       (fwd_data_a),
    .fwd_data_b       (fwd_data_b)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: per-requester stall counts, rotation start, staged write.
  int          m_w[N];
  int          m_ptr;
  bit          m_we;
  int          m_reg;
  logic [31:0] m_data;
  int          m_gid;

  typedef struct {
    bit                  h;
    bit [N-1:0]          v;
    bit [N-1:0][AW-1:0]  r;
    bit [N-1:0][DW-1:0]  d;
    bit [N-1:0]          exp_rdy;
    bit                  exp_we;
    logic [31:0]         exp_pend;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input bit h, input bit [N-1:0] v);
    if (h || v == '0) return -1;
    for (int i = 0; i < N; i++)
      if (v[i] && m_w[i] == MW) return i;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_w[i] = 0;
    m_ptr = 0; m_we = 0; m_reg = 0; m_data = '0; m_gid = 0;
  endtask

  // One clock cycle: drive, check ready before the edge, check outputs after it.
  task automatic cyc(input bit h, input bit [N-1:0] v, input bit [N-1:0][AW-1:0] r,
                     input bit [N-1:0][DW-1:0] d, output int g, output logic [N-1:0] rdy);
    ctrl_hold = h; req_valid = v; req_reg = r; req_data = d;
    g = m_pick(h, v);
    #3;
    rdy = req_ready;
    chk("ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clock); #1;
    if (!h)
      for (int i = 0; i < N; i++)
        m_w[i] = (!v[i] || i == g) ? 0 : ((m_w[i] < MW) ? m_w[i] + 1 : MW);
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_gid = g;
      m_we  = (r[g] != 0);
      if (r[g] != 0) begin m_reg = r[g]; m_data = d[g]; end
    end else m_we = 0;
    chk("we",      64'(ctrl_writeEnable), 64'(m_we));
    chk("wreg",    64'(ctrl_writeReg),    64'(m_reg));
    chk("wdata",   64'(data_writeReg),    64'(m_data));
    chk("pending", 64'(pending_mask),     m_we ? (64'd1 << m_reg) : 64'd0);
    if (m_we) chk("grant_id", 64'(grant_id), 64'(m_gid));
    for (int i = 0; i < N; i++) chk("wait_cnt", 64'(dut.wait_cnt_q[i]), 64'(m_w[i]));
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    ctrl_hold    = 1'b0;
    req_valid    = 3'b111;
    req_reg      = {5'd9, 5'd8, 5'd7};
    #3;
    chk("rst_ready",   64'(req_ready),        64'd0);
    chk("rst_we",      64'(ctrl_writeEnable), 64'd0);
    chk("rst_pending", 64'(pending_mask),     64'd0);
    chk("rst_wreg",    64'(ctrl_writeReg),    64'd0);
    chk("rst_wdata",   64'(data_writeReg),    64'd0);
    chk("rst_gid",     64'(grant_id),         64'd0);
    m_clear();
    req_valid = '0;
    @(negedge clock) ctrl_reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_we", 64'(ctrl_writeEnable), 64'd0);
  endtask

  initial begin
    int g, first2, max_w2;
    logic [N-1:0] rdy;
    bit [N-1:0][DW-1:0] dd;
    bit [N-1:0]         pend;
    bit [N-1:0][AW-1:0] pr;
    bit [N-1:0][DW-1:0] pd;
    bit                 h;

    ctrl_reset_n = 1'b1; ctrl_hold = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
`ifdef REGFILE_ARB_FWD_EN
    fwd_addr_a = '0; fwd_addr_b = '0;
`endif
    dd = {32'hC, 32'hB, 32'hA};
    for (int k = 0; k < 6; k++) begin
      tbl[k] = '{h: 0, v: 3'b111, r: {5'd3, 5'd2, 5'd1}, d: dd,
                 exp_rdy: 3'b001 << (k % 3), exp_we: 1, exp_pend: 32'd2 << (k % 3)};
    end
    tbl[6] = '{h: 0, v: 3'b010, r: {5'd0, 5'd7, 5'd0}, d: {32'h0, 32'hDEADBEEF, 32'h0},
               exp_rdy: 3'b010, exp_we: 1, exp_pend: 32'h80};
    tbl[7] = '{h: 0, v: 3'b000, r: '0, d: '0, exp_rdy: 3'b000, exp_we: 0, exp_pend: 32'h0};

    #1;
    do_reset();

    // Round-robin 0,1,2,0,1,2 then a single write of DEADBEEF to r7.
    for (int k = 0; k < 8; k++) begin
      cyc(tbl[k].h, tbl[k].v, tbl[k].r, tbl[k].d, g, rdy);
      chk("tbl_ready",   64'(rdy),              64'(tbl[k].exp_rdy));
      chk("tbl_we",      64'(ctrl_writeEnable), 64'(tbl[k].exp_we));
      chk("tbl_pending", 64'(pending_mask),     64'(tbl[k].exp_pend));
    end
    chk("single_data", 64'(data_writeReg), 64'h0000_0000_DEAD_BEEF);

    // Escalation: all valid; req2 must be granted within 3 cycles and its
    // stall count must reach MAX_WAIT without exceeding it.
    first2 = -1; max_w2 = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, 3'b111, {5'd12, 5'd11, 5'd10}, dd, g, rdy);
      if (rdy[2] && first2 < 0) first2 = c;
      if (int'(dut.wait_cnt_q[2]) > max_w2) max_w2 = int'(dut.wait_cnt_q[2]);
    end
    chk("esc_latency_ok", 64'((first2 >= 0) && (first2 <= 2)), 64'd1);
    chk("wait_saturate",  64'(max_w2), 64'(MW));

    // Reg 0 write is accepted but never strobes the regfile.
    cyc(0, 3'b001, '0, dd, g, rdy);
    chk("reg0_ready", 64'(rdy), 64'd1);
    chk("reg0_we",    64'(ctrl_writeEnable), 64'd0);
    cyc(0, 3'b111, {5'd4, 5'd5, 5'd6}, dd, g, rdy);
    for (int c = 0; c < 3; c++) begin
      cyc(1, 3'b111, {5'd4, 5'd5, 5'd6}, dd, g, rdy);
      chk("hold_ready", 64'(rdy), 64'd0);
    end
    cyc(0, 3'b111, {5'd4, 5'd5, 5'd6}, dd, g, rdy);
    chk("hold_release", 64'(rdy != '0), 64'd1);

    // Reset right after a transfer to r5: the staged write is discarded.
    cyc(0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h5555_AAAA}, g, rdy);
    chk("mid_staged_we", 64'(ctrl_writeEnable), 64'd1);
`ifdef REGFILE_ARB_FWD_EN
    fwd_addr_a = 5'd5; fwd_addr_b = 5'd6;
    #1;
    chk("fwd_hit_a",  64'(fwd_hit_a),  64'd1);
    chk("fwd_data_a", 64'(fwd_data_a), 64'h5555_AAAA);
    chk("fwd_hit_b",  64'(fwd_hit_b),  64'd0);
    chk("fwd_data_b", 64'(fwd_data_b), 64'd0);
    fwd_addr_a = '0; fwd_addr_b = '0;
`endif
    do_reset();

    // Random traffic: each requester keeps its request stable until granted.
    pend = '0; pr = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pr[i]   = AW'($urandom_range(0, 31));
          pd[i]   = $urandom;
        end
      end
      h = ($urandom_range(0, 7) == 0);
      cyc(h, pend, pr, pd, g, rdy);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
